commit_trace_checker: RTL and testbench

COMMIT_TRACE_CHECKER -- requirements
Module: commit_trace_checker

---
 rtl/sodor5_verif_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 47 ++++
 rtl/commit_trace_checker.sv | 151 +++++++++++++++
 tb/tb_commit_trace_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sodor5_verif_pkg.sv
// Shared definitions for the commit trace checker: state encoding,
// writeback entry layout and small arithmetic helpers.
package sodor5_verif_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RD_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2,
        ST_OVF  = 2'd3
    } chk_state_e;

    typedef struct packed {
        logic [RD_W-1:0]     rd;
        logic [XLEN_DEF-1:0] data;
    } wb_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue; pointers carry one extra wrap bit so that
// full and empty are distinguishable. Push into a full queue succeeds
// when a pop happens on the same edge.
module wb_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign head_valid = (wr_ptr != rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = pop & head_valid;
    assign do_push    = push & (~full | do_pop);
    assign head_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: emptiness is decided by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/commit_trace_checker.sv
// Compares the core and reference-model register writeback streams pair
// by pair, counting matches/mismatches and latching the first bad pair.
module commit_trace_checker
    import sodor5_verif_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            chk_enable,
    input  logic            core_wb_valid,
    input  logic [4:0]      core_wb_rd,
    input  logic [XLEN-1:0] core_wb_data,
    input  logic            model_wb_valid,
    input  logic [4:0]      model_wb_rd,
    input  logic [XLEN-1:0] model_wb_data,
    output logic [31:0]     match_count,
    output logic [31:0]     mismatch_count,
    output logic            mismatch,
    output logic            overflow,
    output logic [4:0]      first_bad_rd,
    output logic [XLEN-1:0] first_bad_core_data,
    output logic [XLEN-1:0] first_bad_model_data,
    output logic [1:0]      state
);

    // state | meaning
    // IDLE  | out of reset, waiting for the first enabled cycle
    // RUN   | comparing, no mismatch seen yet
    // FAIL  | comparing, at least one mismatch recorded
    // OVF   | a queue push was dropped; everything frozen until reset

    logic [1:0] rst_sync;
    logic       rst_int_n;

    // Reset asserts immediately but releases two edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    chk_state_e state_q, state_d;
    wb_entry_t  core_in, model_in, core_head, model_head;
    logic       core_head_valid, model_head_valid;
    logic       core_full, model_full;
    logic       core_push, model_push;
    logic       frozen, comparing, pop_fire, pair_eq;
    logic       core_drop, model_drop, overflow_evt;

    logic [31:0]     match_q, mismatch_cnt_q;
    logic            mismatch_q, overflow_q;
    logic [4:0]      bad_rd_q;
    logic [XLEN-1:0] bad_core_q, bad_model_q;

    assign core_in    = '{rd: core_wb_rd,  data: core_wb_data};
    assign model_in   = '{rd: model_wb_rd, data: model_wb_data};
    assign frozen     = (state_q == ST_OVF);
    assign comparing  = (state_q == ST_RUN) || (state_q == ST_FAIL);
    assign core_push  = core_wb_valid  & chk_enable & (core_wb_rd  != 5'd0) & ~frozen;
    assign model_push = model_wb_valid & chk_enable & (model_wb_rd != 5'd0) & ~frozen;
    assign pop_fire   = comparing & core_head_valid & model_head_valid;
    assign pair_eq    = (core_head == model_head);
    assign core_drop  = core_push  & core_full  & ~pop_fire;
    assign model_drop = model_push & model_full & ~pop_fire;
    assign overflow_evt = core_drop | model_drop;

    wb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(wb_entry_t))) u_core_fifo (
        .clk        (clk),
        .rst_n      (rst_int_n),
        .push       (core_push),
        .push_data  (core_in),
        .pop        (pop_fire),
        .head_data  (core_head),
        .head_valid (core_head_valid),
        .full       (core_full)
    );

    wb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(wb_entry_t))) u_model_fifo (
        .clk        (clk),
        .rst_n      (rst_int_n),
        .push       (model_push),
        .push_data  (model_in),
        .pop        (pop_fire),
        .head_data  (model_head),
        .head_valid (model_head_valid),
        .full       (model_full)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (overflow_evt)    state_d = ST_OVF;
                else if (chk_enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (overflow_evt)              state_d = ST_OVF;
                else if (pop_fire && !pair_eq) state_d = ST_FAIL;
            end
            ST_FAIL: begin
                if (overflow_evt) state_d = ST_OVF;
            end
            ST_OVF:  state_d = ST_OVF;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            match_q        <= '0;
            mismatch_cnt_q <= '0;
            mismatch_q     <= 1'b0;
            overflow_q     <= 1'b0;
            bad_rd_q       <= '0;
            bad_core_q     <= '0;
            bad_model_q    <= '0;
        end else begin
            if (overflow_evt) overflow_q <= 1'b1;
            if (pop_fire) begin
                if (pair_eq) begin
                    match_q <= sat_inc(match_q);
                end else begin
                    mismatch_cnt_q <= sat_inc(mismatch_cnt_q);
                    mismatch_q     <= 1'b1;
                    if (!mismatch_q) begin
                        bad_rd_q    <= core_head.rd;
                        bad_core_q  <= core_head.data;
                        bad_model_q <= model_head.data;
                    end
                end
            end
        end
    end

    assign match_count          = match_q;
    assign mismatch_count       = mismatch_cnt_q;
    assign mismatch             = mismatch_q;
    assign overflow             = overflow_q;
    assign first_bad_rd         = bad_rd_q;
    assign first_bad_core_data  = bad_core_q;
    assign first_bad_model_data = bad_model_q;
    assign state                = state_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed and randomized bench for commit_trace_checker, checked against
// a queue-based reference model of the pairing/compare rules.
module tb_commit_trace_checker;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            chk_enable = 1'b0;
    logic            core_wb_valid = 1'b0;
    logic [4:0]      core_wb_rd = '0;
    logic [XLEN-1:0] core_wb_data = '0;
    logic            model_wb_valid = 1'b0;
    logic [4:0]      model_wb_rd = '0;
    logic [XLEN-1:0] model_wb_data = '0;
    logic [31:0]     match_count, mismatch_count;
    logic            mismatch, overflow;
    logic [4:0]      first_bad_rd;
    logic [XLEN-1:0] first_bad_core_data, first_bad_model_data;
    logic [1:0]      state;

    commit_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .chk_enable           (chk_enable),
        .core_wb_valid        (core_wb_valid),
        .core_wb_rd           (core_wb_rd),
        .core_wb_data         (core_wb_data),
        .model_wb_valid       (model_wb_valid),
        .model_wb_rd          (model_wb_rd),
        .model_wb_data        (model_wb_data),
        .match_count          (match_count),
        .mismatch_count       (mismatch_count),
        .mismatch             (mismatch),
        .overflow             (overflow),
        .first_bad_rd         (first_bad_rd),
        .first_bad_core_data  (first_bad_core_data),
        .first_bad_model_data (first_bad_model_data),
        .state                (state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one queue per side of {rd, data}; states IDLE=0 RUN=1 FAIL=2 OVF=3.
    logic [36:0] cq[$];
    logic [36:0] mq[$];
    logic [36:0] pend[$];
    logic [31:0] m_match, m_mis;
    logic        m_mis_f, m_ovf_f;
    logic [4:0]  m_rd;
    logic [31:0] m_cd, m_md;
    int          m_st;
    int          m_sync;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_clear();
        cq.delete(); mq.delete();
        m_match = 0; m_mis = 0; m_mis_f = 0; m_ovf_f = 0;
        m_rd = 0; m_cd = 0; m_md = 0; m_st = 0; m_sync = 0;
    endtask

    task automatic model_edge();
        logic [36:0] c, m;
        bit          comparing, ovf;
        if (!reset_n) begin model_clear(); return; end
        if (m_sync < 2) begin m_sync++; return; end
        comparing = (m_st == 1 || m_st == 2);
        ovf = 0;
        if (comparing && cq.size() > 0 && mq.size() > 0) begin
            c = cq.pop_front();
            m = mq.pop_front();
            if (c == m) m_match = sat(m_match);
            else begin
                m_mis = sat(m_mis);
                if (!m_mis_f) begin m_rd = c[36:32]; m_cd = c[31:0]; m_md = m[31:0]; end
                m_mis_f = 1;
                if (m_st == 1) m_st = 2;
            end
        end
        if (m_st != 3) begin
            if (core_wb_valid && chk_enable && core_wb_rd != 0) begin
                if (cq.size() < DEPTH) cq.push_back({core_wb_rd, core_wb_data});
                else ovf = 1;
            end
            if (model_wb_valid && chk_enable && model_wb_rd != 0) begin
                if (mq.size() < DEPTH) mq.push_back({model_wb_rd, model_wb_data});
                else ovf = 1;
            end
        end
        if (ovf) begin m_ovf_f = 1; m_st = 3; end
        else if (m_st == 0 && chk_enable) m_st = 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("match_count", 64'(match_count), 64'(m_match));
        chk("mismatch_count", 64'(mismatch_count), 64'(m_mis));
        chk("mismatch", 64'(mismatch), 64'(m_mis_f));
        chk("overflow", 64'(overflow), 64'(m_ovf_f));
        chk("first_bad_rd", 64'(first_bad_rd), 64'(m_rd));
        chk("first_bad_core", 64'(first_bad_core_data), 64'(m_cd));
        chk("first_bad_model", 64'(first_bad_model_data), 64'(m_md));
        chk("state", 64'(state), 64'(m_st));
    endtask

    task automatic idle_inputs();
        core_wb_valid = 0; model_wb_valid = 0;
        core_wb_rd = 0; model_wb_rd = 0;
        core_wb_data = 0; model_wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asserts reset mid-cycle (checking the asynchronous clear), holds it,
    // then waits out the two synchroniser edges before returning.
    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        #1;
        model_clear();
        check_all();
        ticks(2);
        reset_n = 1;
        ticks(2);
    endtask

    task automatic core_wb(input logic [4:0] rd, input logic [31:0] d);
        core_wb_valid = 1; core_wb_rd = rd; core_wb_data = d;
    endtask

    task automatic model_wb(input logic [4:0] rd, input logic [31:0] d);
        model_wb_valid = 1; model_wb_rd = rd; model_wb_data = d;
    endtask

    task automatic random_run(input int cycles);
        logic [36:0] e;
        pend.delete();
        for (int i = 0; i < cycles; i++) begin
            idle_inputs();
            chk_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                core_wb(5'($urandom_range(0, 7)), 32'($urandom_range(0, 15)));
                if (core_wb_rd != 0) pend.push_back({core_wb_rd, core_wb_data});
            end
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                e = pend.pop_front();
                if ($urandom_range(0, 7) == 0) e[3:0] = e[3:0] ^ 4'h5;
                model_wb(e[36:32], e[31:0]);
            end else if ($urandom_range(0, 15) == 0) begin
                model_wb(5'($urandom_range(0, 7)), $urandom);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        model_clear();
        idle_inputs();
        ticks(2);
        do_reset();
        chk("reset_state_idle", 64'(state), 64'd0);

        // Matching pair in the same cycle.
        chk_enable = 1;
        core_wb(5, 32'h1234); model_wb(5, 32'h1234);
        tick();
        idle_inputs();
        tick();
        chk("same_cycle_match", 64'(match_count), 64'd1);
        chk("same_cycle_no_mismatch", 64'(mismatch), 64'd0);
        chk("same_cycle_run", 64'(state), 64'd1);

        // Model lags core by three cycles and disagrees.
        do_reset();
        chk_enable = 1;
        core_wb(7, 32'hA); tick();
        idle_inputs(); ticks(2);
        model_wb(7, 32'hB); tick();
        idle_inputs(); ticks(2);
        chk("late_mis_count", 64'(mismatch_count), 64'd1);
        chk("late_bad_rd", 64'(first_bad_rd), 64'd7);
        chk("late_bad_core", 64'(first_bad_core_data), 64'hA);
        chk("late_bad_model", 64'(first_bad_model_data), 64'hB);
        chk("late_fail_state", 64'(state), 64'd2);
        // A second mismatch must not replace the captured pair.
        core_wb(3, 32'h1); model_wb(3, 32'h2); tick();
        idle_inputs(); ticks(2);
        chk("second_mis_count", 64'(mismatch_count), 64'd2);
        chk("second_mis_keeps_rd", 64'(first_bad_rd), 64'd7);

        // Nine core writebacks, model silent: ninth is dropped.
        do_reset();
        chk_enable = 1;
        for (int i = 1; i <= 9; i++) begin
            core_wb(5'(i), 32'(i * 3)); tick();
        end
        idle_inputs(); tick();
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_state", 64'(state), 64'd3);
        model_wb(1, 32'd3); tick();
        idle_inputs(); ticks(3);
        chk("ovf_frozen_match", 64'(match_count), 64'd0);
        chk("ovf_frozen_mis", 64'(mismatch_count), 64'd0);

        // Writes to x0 never enter the queues.
        do_reset();
        chk_enable = 1;
        core_wb(0, 32'h11); model_wb(0, 32'h22); tick();
        idle_inputs(); ticks(3);
        chk("x0_match", 64'(match_count), 64'd0);
        chk("x0_mis", 64'(mismatch_count), 64'd0);

        // Reset while pairs are draining.
        do_reset();
        chk_enable = 1;
        for (int i = 0; i < 4; i++) begin core_wb(5'(i + 1), 32'(i + 100)); tick(); end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin model_wb(5'(i + 1), 32'(i + 100)); tick(); end
        do_reset();
        chk("midreset_match", 64'(match_count), 64'd0);
        chk("midreset_state", 64'(state), 64'd0);
        chk_enable = 1;
        core_wb(9, 32'h55); model_wb(9, 32'h55); tick();
        idle_inputs(); tick();
        chk("post_reset_count", 64'(match_count), 64'd1);

        // Dropping enable stops pushes but lets queued pairs drain.
        do_reset();
        chk_enable = 1;
        for (int i = 0; i < 3; i++) begin core_wb(5'(i + 2), 32'(i)); tick(); end
        idle_inputs();
        chk_enable = 0;
        for (int i = 0; i < 3; i++) begin model_wb(5'(i + 2), 32'(i)); tick(); end
        idle_inputs(); tick();
        chk("disabled_no_push", 64'(match_count), 64'd0);
        chk_enable = 1;
        for (int i = 0; i < 3; i++) begin model_wb(5'(i + 2), 32'(i)); tick(); end
        chk_enable = 0;
        idle_inputs(); ticks(3);
        chk("drain_all_three", 64'(match_count), 64'd3);
        core_wb(4, 32'h9); model_wb(4, 32'h9); tick();
        idle_inputs(); ticks(3);
        chk("disabled_ignored", 64'(match_count), 64'd3);
        chk("disabled_still_run", 64'(state), 64'd1);

        // Randomized streams against the reference model.
        for (int s = 0; s < 6; s++) begin
            do_reset();
            random_run(300);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
